// File: rtl/s2_sched_pkg.sv
// Shared definitions for the s2 symbol scheduler: FSM state encoding,
// the range reset value, statistics counter width and the fixed
// probability used for bool symbols.
package s2_sched_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } sched_state_e;

    // Coder range after reset or end of frame (2^(RANGE_WIDTH-1) for 16 bits)
    localparam int unsigned RANGE_INIT = 32768;

    // Width of the optional statistics counters
    localparam int unsigned STAT_WIDTH = 32;

    // Bool symbols are coded at probability one half: 16384 >> 6 in Q9
    localparam int unsigned BOOL_PROB_Q = 256;

    // Minimum probability added to every interval bound
    localparam int unsigned MIN_PROB = 4;

endpackage

// File: rtl/s2_rr_arbiter.sv
// Two-requester round-robin arbiter. Requester 0 is the CDF port,
// requester 1 the bool port. After every grant, priority moves to the
// requester that was not granted; i_clear returns priority to CDF.
module s2_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    input  logic       i_clear,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    // Grant: a lone requester wins outright, contention follows the pointer
    always_comb begin
        o_gnt = i_req;
        if (i_req[0] && i_req[1]) begin
            o_gnt = r_ptr ? 2'b10 : 2'b01;
        end
    end

    // Priority pointer: 0 favours CDF, 1 favours bool
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= 1'b0;
        end else if (i_clear) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= o_gnt[0];
        end
    end

endmodule

// File: rtl/stage_2.sv
// Range-update stage of the arithmetic coder (purely combinational).
// Computes the interval bounds u/v from the current range and the CDF
// terms (or the fixed bool probability), the low increment, and the
// renormalised range with its shift count.
module stage_2
    import s2_sched_pkg::*;
#(
    parameter int RANGE_WIDTH = 16,
    parameter int D_SIZE      = 5
) (
    input  logic [RANGE_WIDTH-1:0] in_range,
    input  logic [RANGE_WIDTH-1:0] in_uu,
    input  logic [RANGE_WIDTH-1:0] in_vv,
    input  logic [RANGE_WIDTH-1:0] in_lut_u,
    input  logic [RANGE_WIDTH-1:0] in_lut_v,
    input  logic                   in_comp,
    input  logic                   in_bool,
    input  logic                   in_symbol,
    output logic [RANGE_WIDTH:0]   out_u,
    output logic [RANGE_WIDTH-1:0] out_pre_low,
    output logic [D_SIZE-1:0]      out_d,
    output logic [RANGE_WIDTH-1:0] out_range
);

    localparam int PW = 2 * RANGE_WIDTH;
    localparam int UW = RANGE_WIDTH + 1;

    logic [RANGE_WIDTH-1:0] w_r_hi;
    logic [PW-1:0]          w_prod_u;
    logic [PW-1:0]          w_prod_v;
    logic [PW-1:0]          w_prod_b;
    logic [UW-1:0]          w_u_cdf;
    logic [UW-1:0]          w_v_cdf;
    logic [UW-1:0]          w_v_bool;
    logic [UW-1:0]          w_u_sel;
    logic [UW-1:0]          w_v_sel;
    logic [UW-1:0]          w_range_raw;
    logic [D_SIZE-1:0]      w_lz;

    assign w_r_hi   = in_range >> 8;
    assign w_prod_u = PW'(w_r_hi) * PW'(in_uu);
    assign w_prod_v = PW'(w_r_hi) * PW'(in_vv);
    assign w_prod_b = PW'(w_r_hi) * PW'(BOOL_PROB_Q);
    assign w_u_cdf  = UW'(w_prod_u >> 1) + UW'(in_lut_u);
    assign w_v_cdf  = UW'(w_prod_v >> 1) + UW'(in_lut_v);
    assign w_v_bool = UW'(w_prod_b >> 1) + UW'(MIN_PROB);

    // Bound select: u falls back to the full range when low is untouched
    always_comb begin
        w_u_sel = UW'(in_range);
        w_v_sel = w_v_cdf;
        if (in_bool) begin
            if (in_symbol) begin
                w_u_sel = w_v_bool;
                w_v_sel = '0;
            end else begin
                w_v_sel = w_v_bool;
            end
        end else if (in_comp) begin
            w_u_sel = w_u_cdf;
        end
    end

    assign w_range_raw = w_u_sel - w_v_sel;

    // Leading-zero count of the raw range; an overflowed range is not shifted
    always_comb begin
        w_lz = D_SIZE'(RANGE_WIDTH);
        for (int i = 0; i < RANGE_WIDTH; i++) begin
            if (w_range_raw[i]) begin
                w_lz = D_SIZE'(RANGE_WIDTH - 1 - i);
            end
        end
        if (w_range_raw[RANGE_WIDTH]) begin
            w_lz = '0;
        end
    end

    assign out_u       = w_u_sel;
    assign out_pre_low = in_range - w_u_sel[RANGE_WIDTH-1:0];
    assign out_d       = w_lz;
    assign out_range   = w_range_raw[RANGE_WIDTH-1:0] << w_lz;

endmodule

// File: rtl/s2_symbol_scheduler.sv
// Symbol scheduler around stage_2: arbitrates CDF and bool symbols into
// the range update, owns the coder range register, registers the
// stage-3 bundle and sequences end-of-frame flushes.
// Optional feature macro: S2_SCHED_STATS_EN adds symbol/bit counters.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_RUN   | accepting symbols whenever the output slot frees up
//   ST_DRAIN | flush requested; no accepts, wait for output to empty
//   ST_DONE  | one cycle: pulse flush_done, reset range and pointer
module s2_symbol_scheduler
    import s2_sched_pkg::*;
#(
    parameter int RANGE_WIDTH  = 16,
    parameter int D_SIZE       = 5,
    parameter int SYMBOL_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cdf_valid,
    output logic                    cdf_ready,
    input  logic [RANGE_WIDTH-1:0]  cdf_uu,
    input  logic [RANGE_WIDTH-1:0]  cdf_vv,
    input  logic [RANGE_WIDTH-1:0]  cdf_lut_u,
    input  logic [RANGE_WIDTH-1:0]  cdf_lut_v,
    input  logic                    cdf_comp,
    input  logic                    bool_valid,
    output logic                    bool_ready,
    input  logic [SYMBOL_WIDTH-1:0] bool_symbol,
    input  logic                    flush_req,
    output logic                    flush_done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RANGE_WIDTH:0]    out_u,
    output logic [RANGE_WIDTH-1:0]  out_init_range,
    output logic [RANGE_WIDTH-1:0]  out_pre_low,
    output logic [D_SIZE-1:0]       out_d,
    output logic                    out_comp,
    output logic                    out_bool,
    output logic                    out_symbol,
    output logic                    err_range
`ifdef S2_SCHED_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]   stat_symbols,
    output logic [STAT_WIDTH-1:0]   stat_bits
`endif
);

    sched_state_e r_state;
    sched_state_e w_state_next;

    logic [RANGE_WIDTH-1:0] r_range;
    logic                   r_out_valid;
    logic [RANGE_WIDTH:0]   r_out_u;
    logic [RANGE_WIDTH-1:0] r_out_init_range;
    logic [RANGE_WIDTH-1:0] r_out_pre_low;
    logic [D_SIZE-1:0]      r_out_d;
    logic                   r_out_comp;
    logic                   r_out_bool;
    logic                   r_out_symbol;
    logic                   r_err_range;

    logic [1:0]             w_req;
    logic [1:0]             w_gnt;
    logic                   w_slot_free;
    logic                   w_accept_en;
    logic                   w_accept;
    logic                   w_sel_bool;
    logic                   w_done;
    logic [RANGE_WIDTH:0]   w_u;
    logic [RANGE_WIDTH-1:0] w_pre_low;
    logic [D_SIZE-1:0]      w_d;
    logic [RANGE_WIDTH-1:0] w_range_next;
    logic                   w_unused_sym;

    // Only bit 0 of the bool symbol carries information
    assign w_unused_sym = ^bool_symbol[SYMBOL_WIDTH-1:1];

    assign w_done      = (r_state == ST_DONE);
    assign w_slot_free = !r_out_valid || out_ready;
    // reset gates ready so nothing appears accepted while reset is held
    assign w_accept_en = reset && (r_state == ST_RUN) && w_slot_free;
    assign w_req       = {bool_valid, cdf_valid};
    assign cdf_ready   = w_accept_en && w_gnt[0];
    assign bool_ready  = w_accept_en && w_gnt[1];
    assign w_accept    = (cdf_ready && cdf_valid) || (bool_ready && bool_valid);
    assign w_sel_bool  = w_gnt[1];

    s2_rr_arbiter u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_req     (w_req),
        .i_advance (w_accept),
        .i_clear   (w_done),
        .o_gnt     (w_gnt)
    );

    stage_2 #(
        .RANGE_WIDTH (RANGE_WIDTH),
        .D_SIZE      (D_SIZE)
    ) u_stage_2 (
        .in_range    (r_range),
        .in_uu       (cdf_uu),
        .in_vv       (cdf_vv),
        .in_lut_u    (cdf_lut_u),
        .in_lut_v    (cdf_lut_v),
        .in_comp     (cdf_comp),
        .in_bool     (w_sel_bool),
        .in_symbol   (bool_symbol[0]),
        .out_u       (w_u),
        .out_pre_low (w_pre_low),
        .out_d       (w_d),
        .out_range   (w_range_next)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and flush_done pulse
    always_comb begin
        w_state_next = r_state;
        flush_done   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (flush_req) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_out_valid || out_ready) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                flush_done   = 1'b1;
                w_state_next = ST_RUN;
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // Coder range and sticky range-error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_range     <= RANGE_WIDTH'(RANGE_INIT);
            r_err_range <= 1'b0;
        end else if (w_done) begin
            r_range <= RANGE_WIDTH'(RANGE_INIT);
        end else if (w_accept) begin
            r_range <= w_range_next;
            if (!w_range_next[RANGE_WIDTH-1]) begin
                r_err_range <= 1'b1;
            end
        end
    end

    // Output slot: load on accept, empty when the consumer takes it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid      <= 1'b0;
            r_out_u          <= '0;
            r_out_init_range <= '0;
            r_out_pre_low    <= '0;
            r_out_d          <= '0;
            r_out_comp       <= 1'b0;
            r_out_bool       <= 1'b0;
            r_out_symbol     <= 1'b0;
        end else if (w_accept) begin
            r_out_valid      <= 1'b1;
            r_out_u          <= w_u;
            r_out_init_range <= r_range;
            r_out_pre_low    <= w_pre_low;
            r_out_d          <= w_d;
            r_out_comp       <= !w_sel_bool && cdf_comp;
            r_out_bool       <= w_sel_bool;
            r_out_symbol     <= w_sel_bool && bool_symbol[0];
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid      = r_out_valid;
    assign out_u          = r_out_u;
    assign out_init_range = r_out_init_range;
    assign out_pre_low    = r_out_pre_low;
    assign out_d          = r_out_d;
    assign out_comp       = r_out_comp;
    assign out_bool       = r_out_bool;
    assign out_symbol     = r_out_symbol;
    assign err_range      = r_err_range;

`ifdef S2_SCHED_STATS_EN
    logic [STAT_WIDTH-1:0] r_stat_symbols;
    logic [STAT_WIDTH-1:0] r_stat_bits;

    // Frame statistics: symbols accepted and total renormalisation shift
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_symbols <= '0;
            r_stat_bits    <= '0;
        end else if (w_done) begin
            r_stat_symbols <= '0;
            r_stat_bits    <= '0;
        end else if (w_accept) begin
            r_stat_symbols <= r_stat_symbols + 1'b1;
            r_stat_bits    <= r_stat_bits + STAT_WIDTH'(w_d);
        end
    end

    assign stat_symbols = r_stat_symbols;
    assign stat_bits    = r_stat_bits;
`endif

endmodule

// File: tb/tb_s2_symbol_scheduler.sv
// Self-checking bench for s2_symbol_scheduler. Directed symbols push their
// hand-computed bundles into a queue; a monitor pops and compares on every
// output handshake.
module tb_s2_symbol_scheduler;

    localparam int W  = 16;
    localparam int DS = 5;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cdf_valid = 1'b0;
    logic          cdf_ready;
    logic [W-1:0]  cdf_uu = '0;
    logic [W-1:0]  cdf_vv = '0;
    logic [W-1:0]  cdf_lut_u = '0;
    logic [W-1:0]  cdf_lut_v = '0;
    logic          cdf_comp = 1'b0;
    logic          bool_valid = 1'b0;
    logic          bool_ready;
    logic [SW-1:0] bool_symbol = '0;
    logic          flush_req = 1'b0;
    logic          flush_done;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W:0]    out_u;
    logic [W-1:0]  out_init_range;
    logic [W-1:0]  out_pre_low;
    logic [DS-1:0] out_d;
    logic          out_comp;
    logic          out_bool;
    logic          out_symbol;
    logic          err_range;
`ifdef S2_SCHED_STATS_EN
    logic [31:0]   stat_symbols;
    logic [31:0]   stat_bits;
`endif

    s2_symbol_scheduler #(
        .RANGE_WIDTH  (W),
        .D_SIZE       (DS),
        .SYMBOL_WIDTH (SW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cdf_valid      (cdf_valid),
        .cdf_ready      (cdf_ready),
        .cdf_uu         (cdf_uu),
        .cdf_vv         (cdf_vv),
        .cdf_lut_u      (cdf_lut_u),
        .cdf_lut_v      (cdf_lut_v),
        .cdf_comp       (cdf_comp),
        .bool_valid     (bool_valid),
        .bool_ready     (bool_ready),
        .bool_symbol    (bool_symbol),
        .flush_req      (flush_req),
        .flush_done     (flush_done),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_u          (out_u),
        .out_init_range (out_init_range),
        .out_pre_low    (out_pre_low),
        .out_d          (out_d),
        .out_comp       (out_comp),
        .out_bool       (out_bool),
        .out_symbol     (out_symbol),
        .err_range      (err_range)
`ifdef S2_SCHED_STATS_EN
        ,
        .stat_symbols   (stat_symbols),
        .stat_bits      (stat_bits)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W:0]    u;
        logic [W-1:0]  init;
        logic [W-1:0]  pre;
        logic [DS-1:0] d;
        logic          comp;
        logic          bl;
        logic          sym;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   waited;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input int u, input int init, input int pre, input int d,
                                input bit comp, input bit bl, input bit sym);
        exp_t e;
        e.u    = 17'(u);
        e.init = 16'(init);
        e.pre  = 16'(pre);
        e.d    = 5'(d);
        e.comp = comp;
        e.bl   = bl;
        e.sym  = sym;
        return e;
    endfunction

    // Monitor: compare every delivered bundle against the scoreboard head
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: output with empty queue, got init=%0d d=%0d", out_init_range, out_d);
            end else begin
                m_e = exp_q.pop_front();
                chk("out_u",          32'(out_u),          32'(m_e.u));
                chk("out_init_range", 32'(out_init_range), 32'(m_e.init));
                chk("out_pre_low",    32'(out_pre_low),    32'(m_e.pre));
                chk("out_d",          32'(out_d),          32'(m_e.d));
                chk("out_comp",       32'(out_comp),       32'(m_e.comp));
                chk("out_bool",       32'(out_bool),       32'(m_e.bl));
                chk("out_symbol",     32'(out_symbol),     32'(m_e.sym));
            end
        end
    end

    task automatic set_ops(input logic sym, input logic [W-1:0] uu, input logic [W-1:0] vv,
                           input logic [W-1:0] lu, input logic [W-1:0] lv, input logic comp);
        bool_symbol = {3'b000, sym};
        cdf_uu      = uu;
        cdf_vv      = vv;
        cdf_lut_u   = lu;
        cdf_lut_v   = lv;
        cdf_comp    = comp;
    endtask

    // Offer one symbol and hold it until accepted (bounded)
    task automatic send(input logic is_bool, input logic sym, input logic [W-1:0] uu,
                        input logic [W-1:0] vv, input logic [W-1:0] lu, input logic [W-1:0] lv,
                        input logic comp, output int nwait);
        logic got;
        set_ops(sym, uu, vv, lu, lv, comp);
        if (is_bool) bool_valid = 1'b1;
        else         cdf_valid  = 1'b1;
        got   = 1'b0;
        nwait = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = is_bool ? bool_ready : cdf_ready;
            if (!got) nwait++;
            @(posedge clk);
            #1;
        end
        bool_valid = 1'b0;
        cdf_valid  = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: symbol not accepted, waited %0d cycles", nwait);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d bundles still expected", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        cdf_valid  = 1'b0;
        bool_valid = 1'b0;
        flush_req  = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with requests pending to prove ready stays low
        cdf_valid  = 1'b1;
        bool_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cdf_ready",  32'(cdf_ready),      32'd0);
        chk("rst_bool_ready", 32'(bool_ready),     32'd0);
        chk("rst_out_valid",  32'(out_valid),      32'd0);
        chk("rst_flush_done", 32'(flush_done),     32'd0);
        chk("rst_err_range",  32'(err_range),      32'd0);
        chk("rst_out_init",   32'(out_init_range), 32'd0);
        @(posedge clk);
        #1;
        cdf_valid  = 1'b0;
        bool_valid = 1'b0;
        reset      = 1'b1;

        // Bool 1 from reset, then a second bool to expose range 32776
        exp_q.push_back(mk(16388, 32768, 16380, 1, 0, 1, 1));
        send(1, 1, 0, 0, 0, 0, 0, waited);
        exp_q.push_back(mk(16388, 32776, 16388, 1, 0, 1, 1));
        send(1, 1, 0, 0, 0, 0, 0, waited);
        drain();
        do_reset();

        // Bool 0 from reset, then a CDF that exposes range 65520
        exp_q.push_back(mk(32768, 32768, 0, 2, 0, 1, 0));
        send(1, 0, 0, 0, 0, 0, 0, waited);
        exp_q.push_back(mk(65520, 65520, 0, 0, 0, 0, 0));
        send(0, 0, 0, 0, 0, 4, 0, waited);
        drain();
        do_reset();

        // CDF first-symbol path, general CDF path, then bool at the result
        exp_q.push_back(mk(32768, 32768, 0, 1, 0, 0, 0));
        send(0, 0, 0, 0, 0, 4, 0, waited);
        exp_q.push_back(mk(25508, 65528, 40020, 2, 1, 0, 0));
        send(0, 0, 200, 100, 8, 4, 1, waited);
        exp_q.push_back(mk(51016, 51016, 0, 1, 0, 1, 0));
        send(1, 0, 0, 0, 0, 0, 0, waited);
        drain();
        chk("err_range_clean", 32'(err_range), 32'd0);
        do_reset();

        // Contention: alternating grants, continuous output
        exp_q.push_back(mk(32768, 32768, 0,     1, 0, 0, 0));
        exp_q.push_back(mk(32644, 65528, 32884, 1, 0, 1, 1));
        exp_q.push_back(mk(65288, 65288, 0,     0, 0, 0, 0));
        exp_q.push_back(mk(32644, 65284, 32640, 1, 0, 1, 1));
        set_ops(1, 0, 0, 0, 4, 0);
        cdf_valid  = 1'b1;
        bool_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rr_grant%0d", i), {30'd0, bool_ready, cdf_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) chk($sformatf("rr_out_valid%0d", i), 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        cdf_valid  = 1'b0;
        bool_valid = 1'b0;
        @(negedge clk);
        chk("rr_out_valid4", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        // Stalled output, flush, drain, done pulse and range/pointer reset
        out_ready = 1'b0;
        exp_q.push_back(mk(65288, 65288, 0, 0, 0, 0, 0));
        send(0, 0, 0, 0, 0, 4, 0, waited);
        @(negedge clk);
        chk("stall_init", 32'(out_init_range), 32'd65288);
        @(posedge clk);
        #1;
        flush_req = 1'b1;
        set_ops(1, 0, 0, 0, 4, 0);
        bool_valid = 1'b1;
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drain_bool_ready", 32'(bool_ready), 32'd0);
            chk("drain_flush_done", 32'(flush_done), 32'd0);
            chk("stall_u", 32'(out_u), 32'd65288);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_ready_hs", 32'(bool_ready), 32'd0);
        chk("flush_done_early", 32'(flush_done), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("flush_done_pulse", 32'(flush_done), 32'd1);
        chk("done_bool_ready", 32'(bool_ready), 32'd0);
        @(posedge clk);
        #1;
        exp_q.push_back(mk(32768, 32768, 0,     1, 0, 0, 0));
        exp_q.push_back(mk(32644, 65528, 32884, 1, 0, 1, 1));
        cdf_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("post_flush_grant%0d", i), {30'd0, bool_ready, cdf_ready}, (i == 0) ? 32'd1 : 32'd2);
            if (i == 0) chk("flush_done_after", 32'(flush_done), 32'd0);
            @(posedge clk);
            #1;
        end
        cdf_valid  = 1'b0;
        bool_valid = 1'b0;
        drain();
        do_reset();

        // Degenerate interval: range collapses, sticky error flag
        exp_q.push_back(mk(4, 32768, 32764, 16, 1, 0, 0));
        send(0, 0, 0, 0, 4, 4, 1, waited);
        @(negedge clk);
        chk("err_range_set", 32'(err_range), 32'd1);
        @(posedge clk);
        #1;
        drain();
        chk("err_range_sticky", 32'(err_range), 32'd1);

        // Reset asserted while draining a flush
        out_ready = 1'b0;
        send(0, 0, 0, 0, 0, 4, 0, waited);
        flush_req = 1'b1;
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        @(posedge clk);
        #3;
        cdf_valid  = 1'b1;
        bool_valid = 1'b1;
        reset      = 1'b0;
        #1;
        chk("mid_rst_out_valid",  32'(out_valid),      32'd0);
        chk("mid_rst_out_u",      32'(out_u),          32'd0);
        chk("mid_rst_out_init",   32'(out_init_range), 32'd0);
        chk("mid_rst_out_d",      32'(out_d),          32'd0);
        chk("mid_rst_err_range",  32'(err_range),      32'd0);
        chk("mid_rst_flush_done", 32'(flush_done),     32'd0);
        chk("mid_rst_cdf_ready",  32'(cdf_ready),      32'd0);
        chk("mid_rst_bool_ready", 32'(bool_ready),     32'd0);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        bool_valid = 1'b0;
        out_ready  = 1'b1;
        set_ops(0, 0, 0, 0, 4, 0);
        exp_q.push_back(mk(32768, 32768, 0, 1, 0, 0, 0));
        @(negedge clk);
        chk("post_rst_cdf_ready", 32'(cdf_ready), 32'd1);
        @(posedge clk);
        #1;
        cdf_valid = 1'b0;
        drain();
        chk("final_err_range", 32'(err_range), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/s2_symbol_scheduler.md
S2_SYMBOL_SCHEDULER -- requirements
Module: s2_symbol_scheduler

Interface
REQ-001 Parameter RANGE_WIDTH, default 16, is the range/low datapath width.
REQ-002 Parameter D_SIZE, default 5, is the renormalization shift-count width.
REQ-003 Parameter SYMBOL_WIDTH, default 4, is the bool symbol input width.
REQ-004 Port clk  in  1  is the single clock; all state is on the rising edge.
REQ-005 Port reset  in  1  is the asynchronous, active-low reset.
REQ-006 Port cdf_valid / cdf_ready  in / out  1 / 1  is the CDF symbol handshake.
REQ-007 Port cdf_uu, cdf_vv, cdf_lut_u, cdf_lut_v  in  RANGE_WIDTH each  are the CDF operands (UU, VV, LUT terms).
REQ-008 Port cdf_comp  in  1  is the CDF "first symbol" mux select (COMP_mux_1).
REQ-009 Port bool_valid / bool_ready  in / out  1 / 1  is the bool symbol handshake.
REQ-010 Port bool_symbol  in  SYMBOL_WIDTH  is the bool symbol; only bit 0 is significant.
REQ-011 Port flush_req  in  1  is a single-cycle end-of-frame request.
REQ-012 Port flush_done  out  1  is a single-cycle pulse when the flush is complete.
REQ-013 Ports out_valid / out_ready  out / in  1 / 1  are the stage-3 handshake.
REQ-014 Ports out_u (RANGE_WIDTH+1), out_init_range, out_pre_low (RANGE_WIDTH), out_d (D_SIZE), out_comp, out_bool, out_symbol (1)  out  form the registered stage-3 bundle.
REQ-015 Port err_range  out  1  is a sticky flag: a renormalized range had its MSB clear.

Function
REQ-016 The block SHALL instantiate stage_2 once and own range_q, which feeds stage_2 in_range; range_q resets to 2^(RANGE_WIDTH-1) (32768).
REQ-017 States: RUN, DRAIN, DONE; the reset state is RUN.
REQ-018 In RUN, a symbol is accepted when the output slot is empty or (out_valid && out_ready) in the same cycle; at most one accept per cycle.
REQ-019 When both valid inputs are asserted, the grant is round-robin (the pointer flips after each grant; reset pointer = CDF); a single requester is granted immediately.
REQ-020 cdf_ready and bool_ready are asserted only for the granted requester in an accepting cycle; operands are sampled at valid&&ready.
REQ-021 On accept: range_q <= stage_2 out_range; the output bundle is registered; out_valid = 1 on the next cycle (latency 1).
REQ-022 out_valid holds, with a stable bundle, until out_ready; back-to-back accepts sustain 1 symbol/cycle.
REQ-023 A flush_req in RUN moves to DRAIN; an accept in the same cycle is still taken.
REQ-024 DRAIN: no accepts; DRAIN -> DONE once out_valid is 0 or its handshake completes.
REQ-025 DONE (one cycle): flush_done = 1; range_q <= 32768; grant pointer <= CDF; -> RUN.
REQ-026 flush_req in DRAIN or DONE is ignored.
REQ-027 err_range sets when the accepted range_q next value has bit RANGE_WIDTH-1 = 0; it clears only on reset.

Reset
REQ-028 Asserting reset at any time, including mid-symbol or mid-flush, SHALL force: state RUN, range_q = 32768, pointer = CDF, out_valid = 0, bundle = 0, ready outputs = 0, flush_done = 0, err_range = 0.

Configuration
REQ-029 With S2_SCHED_STATS_EN defined: outputs stat_symbols (32) and stat_bits (32, sum of out_d) increment on each accept, wrap modulo 2^32, and clear at reset and in DONE.
REQ-030 Without S2_SCHED_STATS_EN: the stat ports and their counters do not exist; all other behaviour is identical.

Structure
REQ-031 The shared package s2_sched_pkg holds the state enum, RANGE_INIT = 32768, and the stat counter width.
REQ-032 Arbitration lives in the sub-module s2_rr_arbiter (2 requesters, request/grant/advance).

Verification
REQ-033 After reset, bool_symbol=1 -> out_pre_low=16380, out_d=1, next range_q=32776, out_bool=1.
REQ-034 After reset, bool_symbol=0 -> out_d=2, next range_q=65520, out_symbol=0.
REQ-035 After reset, CDF with cdf_comp=0, cdf_vv=0, cdf_lut_v=4 -> out_d=1, next range_q=65528.
REQ-036 Both valid for 4 cycles with out_ready=1 -> grants CDF, bool, CDF, bool; out_valid is continuous.
REQ-037 out_ready=0 with out_valid=1, then flush_req -> no further accepts; flush_done pulses 1 cycle after out_ready rises; range_q=32768.
REQ-038 reset asserted in DRAIN -> all outputs 0 immediately, and a CDF accept is possible on the first cycle after release.
